traffic_lamp_driver: RTL and testbench
======================================

TRAFFIC_LAMP_DRIVER -- requirements
Module: traffic_lamp_driver

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 4, meaning clock cycles per half-period of the fault flash.
REQ-002 SHALL have parameter WALK_CYCLES, default 5 (range 1..8), meaning clock cycles of walk indication per serviced request.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 SHALL have port traffic_state  input  2  phase from upstream controller: 00 NS green, 01 NS yellow, 10 EW green, 11 EW yellow.
REQ-006 SHALL have port ped_req  input  1  pedestrian button, level, any duration, synchronous to clk.
REQ-007 SHALL have port ns_lamp  output  3  {red,yellow,green} for north-south, one-hot in normal operation.
REQ-008 SHALL have port ew_lamp  output  3  {red,yellow,green} for east-west.
REQ-009 SHALL have port walk  output  1  pedestrian walk indication (crossing EW road during NS green).
REQ-010 SHALL have port walk_count  output  3  remaining walk cycles, counting down.
REQ-011 SHALL have port fault  output  1  sticky illegal-sequence flag.

Function
REQ-012 All outputs SHALL be registered; lamps reflect traffic_state sampled at edge k, visible after edge k (1-cycle latency).
REQ-013 Decode SHALL be: 00 -> ns=001, ew=100; 01 -> ns=010, ew=100; 10 -> ns=100, ew=001; 11 -> ns=100, ew=010.
REQ-014 Block SHALL keep prev_state and a primed flag; first sample after reset sets primed without a sequence check.
REQ-015 When primed and traffic_state != prev_state, the only legal new value SHALL be prev_state+1 mod 4 (11 -> 00 wrap legal); an unchanged state is always legal.
REQ-016 Illegal transition SHALL set fault=1 at the same edge the lamps would update and enter FAULT mode.
REQ-017 FAULT mode: ns_lamp=ew_lamp={0,blink,0}, blink toggling every BLINK_DIV cycles starting at 1; walk=0; walk_count=0; traffic_state ignored; exit only by reset.
REQ-018 ped_req rising edge (0 at edge k-1, 1 at edge k) SHALL set ped_pending; a held level SHALL NOT create further requests.
REQ-019 Walk FSM SHALL have states IDLE, WAIT, WALK; IDLE -> WAIT when ped_pending set.
REQ-020 WAIT -> WALK on NS-green entry (prev_state != 00, traffic_state == 00, legal); ped_pending cleared at that edge.
REQ-021 A request arriving while traffic_state is already 00 SHALL wait for the next NS-green entry.
REQ-022 On WALK entry: walk=1, walk_count=WALK_CYCLES-1; decrement by 1 each cycle while nonzero.
REQ-023 WALK -> IDLE (walk=0, walk_count=0) on the edge after walk_count reaches 0, or at the edge where traffic_state leaves 00, whichever first.
REQ-024 Requests during WAIT SHALL merge into the one pending; a request during WALK SHALL set ped_pending and go to WAIT after WALK ends.
REQ-025 Fault during WALK SHALL force walk=0 and walk_count=0 at the faulting edge.

Reset
REQ-026 With reset=0 at a rising edge: ns_lamp=100, ew_lamp=100, walk=0, walk_count=0, fault=0, ped_pending=0, primed=0, blink=0, walk FSM=IDLE.
REQ-027 Reset SHALL override all other events in the same cycle, including mid-WALK and FAULT.

Verification
REQ-028 Sequence 00,01,10,11,00 each held 3 cycles after reset -> lamps per REQ-013 with 1-cycle lag, fault=0 throughout.
REQ-029 ped_req pulse during state 10, then 11 -> 00 -> walk=1 with walk_count=4,3,2,1,0 over 5 cycles (WALK_CYCLES=5), then walk=0.
REQ-030 ped_req held high 20 cycles across two NS-green entries -> exactly one walk period.
REQ-031 State 00 -> 10 jump -> fault=1 next edge, both yellows flash 4 on / 4 off, walk=0; remains until reset=0.
REQ-032 Walk active, traffic_state 00 -> 01 after 2 walk cycles -> walk=0 at that edge; reset=0 mid-walk -> all REQ-026 values next edge.

Source files
------------

// File: rtl/traffic_lamp_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : traffic_lamp_driver
//  Description : Decodes the upstream traffic phase into registered NS/EW
//                lamp drives, checks the phase sequence for legality (sticky
//                fault with flashing yellows), and runs a pedestrian walk
//                sequencer that grants a walk window at each NS-green entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_lamp_driver #(
    parameter int BLINK_DIV   = 4,
    parameter int WALK_CYCLES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] traffic_state,
    input  logic       ped_req,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       walk,
    output logic [2:0] walk_count,
    output logic       fault
);

    // Walk sequencer states
    localparam logic [1:0] c_idle = 2'b00;
    localparam logic [1:0] c_wait = 2'b01;
    localparam logic [1:0] c_walk = 2'b10;

    localparam logic [2:0] c_walk_init  = 3'(WALK_CYCLES - 1);
    localparam int         c_bw         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_bw-1:0] c_blink_last = c_bw'(BLINK_DIV - 1);

    // Lamp encodings {red,yellow,green}
    localparam logic [2:0] c_red    = 3'b100;
    localparam logic [2:0] c_yellow = 3'b010;
    localparam logic [2:0] c_green  = 3'b001;

    logic [1:0]      r_prev_state;
    logic            r_primed;
    logic            r_fault;
    logic            r_blink;
    logic [c_bw-1:0] r_blink_cnt;
    logic            r_ped_prev;
    logic            r_ped_pending;
    logic [1:0]      r_walk_state;
    logic [2:0]      r_walk_count;
    logic            r_walk;

    logic [1:0]      w_state_next;
    logic [2:0]      w_count_next;
    logic            w_walk_next;

    logic [1:0]      w_seq_next;
    logic            w_illegal;
    logic            w_ns_entry;
    logic            w_ped_rise;
    logic            w_kill;

    // Only "stay" or "advance by one (mod 4)" is a legal phase change.
    assign w_seq_next = r_prev_state + 2'd1;
    assign w_illegal  = !r_fault && r_primed &&
                        (traffic_state != r_prev_state) &&
                        (traffic_state != w_seq_next);
    assign w_ns_entry = !r_fault && r_primed && !w_illegal &&
                        (r_prev_state != 2'b00) && (traffic_state == 2'b00);
    assign w_ped_rise = ped_req && !r_ped_prev;
    // Fault (new or standing) shuts the walk machinery down at once.
    assign w_kill     = r_fault || w_illegal;

    // Track the last accepted phase and latch the sticky fault flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_state <= 2'b00;
            r_primed     <= 1'b0;
            r_fault      <= 1'b0;
        end else if (!r_fault) begin
            if (w_illegal) begin
                r_fault <= 1'b1;
            end else begin
                r_prev_state <= traffic_state;
                r_primed     <= 1'b1;
            end
        end
    end

    // Drive the lamps: phase decode normally, flashing yellows when faulted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ns_lamp     <= c_red;
            ew_lamp     <= c_red;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_illegal) begin
            // Flash starts in the "on" half at the faulting edge.
            ns_lamp     <= c_yellow;
            ew_lamp     <= c_yellow;
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (r_fault) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
                ns_lamp     <= {1'b0, ~r_blink, 1'b0};
                ew_lamp     <= {1'b0, ~r_blink, 1'b0};
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            case (traffic_state)
                2'b00:   begin ns_lamp <= c_green;  ew_lamp <= c_red;    end
                2'b01:   begin ns_lamp <= c_yellow; ew_lamp <= c_red;    end
                2'b10:   begin ns_lamp <= c_red;    ew_lamp <= c_green;  end
                default: begin ns_lamp <= c_red;    ew_lamp <= c_yellow; end
            endcase
        end
    end

    // Edge-detect the button and hold one merged pending request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ped_prev    <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            r_ped_prev <= ped_req;
            if (w_kill) begin
                r_ped_pending <= 1'b0;
            end else if ((r_walk_state == c_wait) && w_ns_entry) begin
                r_ped_pending <= 1'b0;
            end else if (w_ped_rise) begin
                r_ped_pending <= 1'b1;
            end
        end
    end

    // Walk sequencer state register (outputs registered alongside).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_walk_state <= c_idle;
            r_walk_count <= 3'd0;
            r_walk       <= 1'b0;
        end else begin
            r_walk_state <= w_state_next;
            r_walk_count <= w_count_next;
            r_walk       <= w_walk_next;
        end
    end

    // Walk sequencer next-state and countdown.
    always_comb begin
        w_state_next = r_walk_state;
        w_count_next = r_walk_count;
        case (r_walk_state)
            c_idle: begin
                if (r_ped_pending) w_state_next = c_wait;
            end
            c_wait: begin
                if (w_ns_entry) begin
                    w_state_next = c_walk;
                    w_count_next = c_walk_init;
                end
            end
            c_walk: begin
                // Leaving NS green cuts the walk short.
                if ((traffic_state != 2'b00) || (r_walk_count == 3'd0)) begin
                    w_state_next = c_idle;
                    w_count_next = 3'd0;
                end else begin
                    w_count_next = r_walk_count - 3'd1;
                end
            end
            default: begin
                w_state_next = c_idle;
                w_count_next = 3'd0;
            end
        endcase
        if (w_kill) begin
            w_state_next = c_idle;
            w_count_next = 3'd0;
        end
    end

    // Walk indication follows the upcoming sequencer state.
    always_comb begin
        w_walk_next = (w_state_next == c_walk);
    end

    assign walk       = r_walk;
    assign walk_count = r_walk_count;
    assign fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lamp_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_lamp_driver
//  Description : Scenario bench for traffic_lamp_driver; each step pushes the
//                expected registered outputs and pops them after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_lamp_driver;

    localparam int BLINK_DIV   = 4;
    localparam int WALK_CYCLES = 5;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic [2:0] cnt;
        logic       fault;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] traffic_state = 2'b00;
    logic       ped_req = 1'b0;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic       walk;
    logic [2:0] walk_count;
    logic       fault;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    traffic_lamp_driver #(
        .BLINK_DIV   (BLINK_DIV),
        .WALK_CYCLES (WALK_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .traffic_state (traffic_state),
        .ped_req       (ped_req),
        .ns_lamp       (ns_lamp),
        .ew_lamp       (ew_lamp),
        .walk          (walk),
        .walk_count    (walk_count),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [2:0] ns, logic [2:0] ew, logic w, logic [2:0] c, logic f);
        exp_t e;
        e.ns = ns; e.ew = ew; e.walk = w; e.cnt = c; e.fault = f;
        return e;
    endfunction

    // Phase decode table: NS/EW lamps for each traffic_state
    function automatic exp_t dec(logic [1:0] ts);
        case (ts)
            2'b00:   return mk(3'b001, 3'b100, 1'b0, 3'd0, 1'b0);
            2'b01:   return mk(3'b010, 3'b100, 1'b0, 3'd0, 1'b0);
            2'b10:   return mk(3'b100, 3'b001, 1'b0, 3'd0, 1'b0);
            default: return mk(3'b100, 3'b010, 1'b0, 3'd0, 1'b0);
        endcase
    endfunction

    function automatic exp_t rst_val();
        return mk(3'b100, 3'b100, 1'b0, 3'd0, 1'b0);
    endfunction

    // Apply inputs on the falling edge, queue the expectation, settle after the rising edge.
    task automatic drive(input logic [1:0] ts, input logic pr, input logic rs, input exp_t e);
        @(negedge clk);
        traffic_state = ts;
        ped_req       = pr;
        reset         = rs;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, g;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 1'b0, 1'b0, rst_val());
            e = sb.pop_front();
            g = {ns_lamp, ew_lamp, walk, walk_count, fault};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got ns=%b ew=%b walk=%b cnt=%0d fault=%b, expected ns=%b ew=%b walk=%b cnt=%0d fault=%b",
                         i, g.ns, g.ew, g.walk, g.cnt, g.fault, e.ns, e.ew, e.walk, e.cnt, e.fault);
            end
        end
    endtask

    task automatic test_sequence();
        int   seq [5] = '{0, 1, 2, 3, 0};
        exp_t e, g;
        for (int s = 0; s < 5; s++) begin
            for (int r = 0; r < 3; r++) begin
                drive(2'(seq[s]), 1'b0, 1'b1, dec(2'(seq[s])));
                e = sb.pop_front();
                g = {ns_lamp, ew_lamp, walk, walk_count, fault};
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL sequence[%0d.%0d]: got ns=%b ew=%b walk=%b cnt=%0d fault=%b, expected ns=%b ew=%b walk=%b cnt=%0d fault=%b",
                             s, r, g.ns, g.ew, g.walk, g.cnt, g.fault, e.ns, e.ew, e.walk, e.cnt, e.fault);
                end
            end
        end
    endtask

    // Pulse during EW green; full walk window at the next NS-green entry.
    task automatic test_walk();
        int   ts [13] = '{1, 2, 2, 2, 3, 3, 0, 0, 0, 0, 0, 0, 0};
        int   pr [13] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_t e, g, x;
        for (int k = 0; k < 13; k++) begin
            x = dec(2'(ts[k]));
            if (k >= 6 && k - 6 < WALK_CYCLES) begin
                x.walk = 1'b1;
                x.cnt  = 3'(WALK_CYCLES - 1 - (k - 6));
            end
            drive(2'(ts[k]), 1'(pr[k]), 1'b1, x);
            e = sb.pop_front();
            g = {ns_lamp, ew_lamp, walk, walk_count, fault};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL walk[%0d]: got ns=%b ew=%b walk=%b cnt=%0d fault=%b, expected ns=%b ew=%b walk=%b cnt=%0d fault=%b",
                         k, g.ns, g.ew, g.walk, g.cnt, g.fault, e.ns, e.ew, e.walk, e.cnt, e.fault);
            end
        end
    endtask

    // Button held across two NS-green entries yields one walk only.
    task automatic test_held();
        int   ts [21] = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_t e, g, x;
        for (int k = 0; k < 21; k++) begin
            x = dec(2'(ts[k]));
            if (k >= 3 && k - 3 < WALK_CYCLES) begin
                x.walk = 1'b1;
                x.cnt  = 3'(WALK_CYCLES - 1 - (k - 3));
            end
            drive(2'(ts[k]), (k < 20), 1'b1, x);
            e = sb.pop_front();
            g = {ns_lamp, ew_lamp, walk, walk_count, fault};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL held[%0d]: got ns=%b ew=%b walk=%b cnt=%0d fault=%b, expected ns=%b ew=%b walk=%b cnt=%0d fault=%b",
                         k, g.ns, g.ew, g.walk, g.cnt, g.fault, e.ns, e.ew, e.walk, e.cnt, e.fault);
            end
        end
    endtask

    // Request during NS green waits for the next entry; leaving 00 aborts the walk.
    task automatic test_abort();
        int   ts [13] = '{0, 0, 0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0};
        int   pr [13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_t e, g, x;
        for (int k = 0; k < 13; k++) begin
            x = dec(2'(ts[k]));
            if (k == 6 || k == 7) begin
                x.walk = 1'b1;
                x.cnt  = 3'(WALK_CYCLES - 1 - (k - 6));
            end
            drive(2'(ts[k]), 1'(pr[k]), 1'b1, x);
            e = sb.pop_front();
            g = {ns_lamp, ew_lamp, walk, walk_count, fault};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL abort[%0d]: got ns=%b ew=%b walk=%b cnt=%0d fault=%b, expected ns=%b ew=%b walk=%b cnt=%0d fault=%b",
                         k, g.ns, g.ew, g.walk, g.cnt, g.fault, e.ns, e.ew, e.walk, e.cnt, e.fault);
            end
        end
    endtask

    // Reset asserted in the middle of a walk window.
    task automatic test_reset_midwalk();
        int   ts [8] = '{1, 2, 3, 0, 0, 0, 0, 0};
        int   pr [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        int   rs [8] = '{1, 1, 1, 1, 1, 0, 0, 1};
        exp_t e, g, x;
        for (int k = 0; k < 8; k++) begin
            x = (rs[k] == 0) ? rst_val() : dec(2'(ts[k]));
            if (k == 3 || k == 4) begin
                x.walk = 1'b1;
                x.cnt  = 3'(WALK_CYCLES - 1 - (k - 3));
            end
            drive(2'(ts[k]), 1'(pr[k]), 1'(rs[k]), x);
            e = sb.pop_front();
            g = {ns_lamp, ew_lamp, walk, walk_count, fault};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_midwalk[%0d]: got ns=%b ew=%b walk=%b cnt=%0d fault=%b, expected ns=%b ew=%b walk=%b cnt=%0d fault=%b",
                         k, g.ns, g.ew, g.walk, g.cnt, g.fault, e.ns, e.ew, e.walk, e.cnt, e.fault);
            end
        end
    endtask

    // Illegal 00 -> 10 jump mid-walk: sticky fault, flashing yellows, reset recovers.
    task automatic test_fault();
        int   ts [6] = '{1, 2, 3, 0, 0, 2};
        int   pr [6] = '{1, 0, 0, 0, 0, 0};
        exp_t e, g, x;
        logic b;
        for (int k = 0; k < 6 + 16 + 2; k++) begin
            if (k < 5) begin
                x = dec(2'(ts[k]));
                if (k >= 3) begin
                    x.walk = 1'b1;
                    x.cnt  = 3'(WALK_CYCLES - 1 - (k - 3));
                end
                drive(2'(ts[k]), 1'(pr[k]), 1'b1, x);
            end else if (k < 22) begin
                b = (((k - 5) / BLINK_DIV) % 2) == 0;
                x = mk({1'b0, b, 1'b0}, {1'b0, b, 1'b0}, 1'b0, 3'd0, 1'b1);
                if (k == 5) drive(2'(ts[5]), 1'b0, 1'b1, x);
                else        drive(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b1, x);
            end else if (k == 22) begin
                drive(2'b00, 1'b0, 1'b0, rst_val());
            end else begin
                drive(2'b00, 1'b0, 1'b1, dec(2'b00));
            end
            e = sb.pop_front();
            g = {ns_lamp, ew_lamp, walk, walk_count, fault};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL fault[%0d]: got ns=%b ew=%b walk=%b cnt=%0d fault=%b, expected ns=%b ew=%b walk=%b cnt=%0d fault=%b",
                         k, g.ns, g.ew, g.walk, g.cnt, g.fault, e.ns, e.ew, e.walk, e.cnt, e.fault);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequence();
        test_walk();
        test_held();
        test_abort();
        test_reset_midwalk();
        test_fault();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
